fetch_redirect_ctrl: RTL and testbench

//  Owns the fetch PC and sequences redirects. Each cycle it picks the next PC from three

---
 rtl/common_types_pkg.sv | 14 +
 rtl/sat_counter.sv | 32 +++
 rtl/fetch_redirect_ctrl.sv | 124 ++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/common_types_pkg.sv
// Shared types for the fetch front end.
// Provides word_t, redirect_state_t and the default reset PC.
package common_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } redirect_state_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, cleared by synchronous active-high reset.
// Ports: clk, rst, inc (count enable), count (current value).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: picks next PC (sequential / predicted / mispredict
// recovery), pulses front-end flushes, drains an unabortable imem fetch
// before redirecting.
// Inputs: clk, rst, mem_branch/mem_flush/mem_taken/mem_pc/mem_target_res
//   from MEM, fetch_predict/fetch_target from the branch unit,
//   hazard_stall, imem_ready.
// Outputs: pc, imem_req, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush,
//   perf_branches/perf_mispredicts (only with BRANCH_PERF_EN defined).
module fetch_redirect_ctrl
    import common_types_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT,
    parameter int    CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_branch,
    input  logic             mem_flush,
    input  logic             mem_taken,
    input  word_t            mem_pc,
    input  word_t            mem_target_res,
    input  logic             fetch_predict,
    input  word_t            fetch_target,
    input  logic             hazard_stall,
    input  logic             imem_ready,
    output word_t            pc,
    output logic             imem_req,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
`ifdef BRANCH_PERF_EN
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts,
`endif
    output logic             ex_mem_flush
);

    redirect_state_t state_q;
    redirect_state_t state_d;
    word_t           pc_q;
    word_t           pc_d;
    word_t           redir_q;
    word_t           redir_d;

    logic  mispredict;
    logic  flush;
    word_t redirect_pc;

    assign mispredict  = mem_branch & mem_flush;
    assign redirect_pc = mem_taken ? mem_target_res : (mem_pc + 32'd4);
    assign imem_req    = ~rst;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        redir_d  = redir_q;
        if_id_en = 1'b0;
        flush    = 1'b0;
        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    flush = mispredict;
                    if (mispredict) begin
                        if (imem_ready || !imem_req) begin
                            pc_d = redirect_pc;
                        end else begin
                            // Fetch in flight cannot be aborted: park target.
                            redir_d = redirect_pc;
                            state_d = DRAIN;
                        end
                    end else if (imem_ready && !hazard_stall) begin
                        if_id_en = 1'b1;
                        pc_d     = fetch_predict ? fetch_target
                                                 : (pc_q + 32'd4);
                    end
                end
                DRAIN: begin
                    // Returned word belongs to the wrong path; drop it.
                    if (imem_ready) begin
                        pc_d    = redir_q;
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
        end
    end

    assign pc           = pc_q;
    assign if_id_flush  = flush;
    assign id_ex_flush  = flush;
    assign ex_mem_flush = flush;

`ifdef BRANCH_PERF_EN
    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_branch),
        .count (perf_branches)
    );

    sat_counter #(.W(CNT_W)) u_mispredict_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mispredict),
        .count (perf_mispredicts)
    );
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl with an expectation queue.
// Optional BRANCH_PERF_EN adds counter checks.
module tb_fetch_redirect_ctrl;
    import common_types_pkg::*;

    localparam int CNT_W = 4;

    logic  clk = 1'b0;
    logic  rst;
    logic  mem_branch;
    logic  mem_flush;
    logic  mem_taken;
    word_t mem_pc;
    word_t mem_target_res;
    logic  fetch_predict;
    word_t fetch_target;
    logic  hazard_stall;
    logic  imem_ready;
    word_t pc;
    logic  imem_req;
    logic  if_id_en;
    logic  if_id_flush;
    logic  id_ex_flush;
    logic  ex_mem_flush;
`ifdef BRANCH_PERF_EN
    logic [CNT_W-1:0] perf_branches;
    logic [CNT_W-1:0] perf_mispredicts;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        string tag;
        word_t pc;
        logic  req;
        logic  en;
        logic  fl;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_redirect_ctrl #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_branch       (mem_branch),
        .mem_flush        (mem_flush),
        .mem_taken        (mem_taken),
        .mem_pc           (mem_pc),
        .mem_target_res   (mem_target_res),
        .fetch_predict    (fetch_predict),
        .fetch_target     (fetch_target),
        .hazard_stall     (hazard_stall),
        .imem_ready       (imem_ready),
        .pc               (pc),
        .imem_req         (imem_req),
        .if_id_en         (if_id_en),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
`ifdef BRANCH_PERF_EN
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts),
`endif
        .ex_mem_flush     (ex_mem_flush)
    );

    // A mispredict must never arrive while draining.
    always @(negedge clk) begin
        if (!rst && dut.state_q == DRAIN) begin
            checks++;
            assert (!(mem_branch && mem_flush)) else begin
                errors++;
                $error("FAIL drain_mispredict got=1 want=0");
            end
        end
    end

    task automatic chk1(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Push expectation for this cycle, compare mid-cycle, advance.
    task automatic cyc(input string tag, input word_t epc,
                       input logic ereq, input logic een, input logic efl);
        exp_t e;
        exp_t p;
        e.tag = tag;
        e.pc  = epc;
        e.req = ereq;
        e.en  = een;
        e.fl  = efl;
        sb.push_back(e);
        @(negedge clk);
        p = sb.pop_front();
        chk1({p.tag, ".pc"}, pc, p.pc);
        chk1({p.tag, ".req"}, {31'd0, imem_req}, {31'd0, p.req});
        chk1({p.tag, ".en"}, {31'd0, if_id_en}, {31'd0, p.en});
        chk1({p.tag, ".flush"},
             {29'd0, if_id_flush, id_ex_flush, ex_mem_flush},
             {29'd0, p.fl, p.fl, p.fl});
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic f, input logic t, input word_t mpc,
                      input word_t tgt);
        mem_branch     = 1'b1;
        mem_flush      = f;
        mem_taken      = t;
        mem_pc         = mpc;
        mem_target_res = tgt;
    endtask

    task automatic nobr();
        mem_branch     = 1'b0;
        mem_flush      = 1'b0;
        mem_taken      = 1'b0;
        mem_pc         = '0;
        mem_target_res = '0;
    endtask

    initial begin
        word_t pexp;
        rst           = 1'b1;
        fetch_predict = 1'b0;
        fetch_target  = '0;
        hazard_stall  = 1'b0;
        imem_ready    = 1'b1;
        nobr();
        @(posedge clk);
        #1;
        cyc("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Sequential fetch
        cyc("seq0", 32'h0, 1'b1, 1'b1, 1'b0);
        cyc("seq1", 32'h4, 1'b1, 1'b1, 1'b0);
        cyc("seq2", 32'h8, 1'b1, 1'b1, 1'b0);
        cyc("seq3", 32'hC, 1'b1, 1'b1, 1'b0);

        // Predicted taken
        fetch_predict = 1'b1;
        fetch_target  = 32'h80;
        cyc("pred", 32'h10, 1'b1, 1'b1, 1'b0);
        fetch_predict = 1'b0;

        // Mispredict with ready fetch
        br(1'b1, 1'b1, 32'h70, 32'h200);
        cyc("mp_rdy", 32'h80, 1'b1, 1'b0, 1'b1);
        nobr();
        cyc("mp_rdy_tgt", 32'h200, 1'b1, 1'b1, 1'b0);

        // Mispredict into drain
        imem_ready = 1'b0;
        br(1'b1, 1'b0, 32'h40, 32'h999);
        cyc("drain_mp", 32'h204, 1'b1, 1'b0, 1'b1);
        nobr();
        cyc("drain1", 32'h204, 1'b1, 1'b0, 1'b0);
        cyc("drain2", 32'h204, 1'b1, 1'b0, 1'b0);
        imem_ready = 1'b1;
        cyc("drain_drop", 32'h204, 1'b1, 1'b0, 1'b0);
        cyc("drain_tgt", 32'h44, 1'b1, 1'b1, 1'b0);

        // Hazard stall, then mispredict during stall
        br(1'b1, 1'b1, 32'h10, 32'h20);
        cyc("to20", 32'h48, 1'b1, 1'b0, 1'b1);
        nobr();
        hazard_stall = 1'b1;
        cyc("stall0", 32'h20, 1'b1, 1'b0, 1'b0);
        cyc("stall1", 32'h20, 1'b1, 1'b0, 1'b0);
        br(1'b1, 1'b1, 32'h18, 32'h300);
        cyc("stall_mp", 32'h20, 1'b1, 1'b0, 1'b1);
        nobr();
        hazard_stall = 1'b0;
        cyc("stall_tgt", 32'h300, 1'b1, 1'b1, 1'b0);

        // Not-taken wrap at top of address space
        br(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h5555);
        cyc("wrap_mp", 32'h304, 1'b1, 1'b0, 1'b1);
        nobr();
        cyc("wrap_tgt", 32'h0, 1'b1, 1'b1, 1'b0);

        // Stray mem_flush without branch is ignored
        mem_flush = 1'b1;
        cyc("stray_flush", 32'h4, 1'b1, 1'b1, 1'b0);
        mem_flush = 1'b0;

        // imem not ready in RUN holds pc
        imem_ready = 1'b0;
        cyc("not_ready", 32'h8, 1'b1, 1'b0, 1'b0);
        imem_ready = 1'b1;
        cyc("ready_again", 32'h8, 1'b1, 1'b1, 1'b0);

        // 20 branches, 17 mispredicts
        pexp = 32'hC;
        for (int i = 0; i < 20; i++) begin
            br(i < 17, 1'b1, 32'h0, 32'h1000 + 32'(i) * 32'h10);
            if (i < 17) begin
                cyc("burst_mp", pexp, 1'b1, 1'b0, 1'b1);
                pexp = 32'h1000 + 32'(i) * 32'h10;
            end else begin
                cyc("burst_ok", pexp, 1'b1, 1'b1, 1'b0);
                pexp = pexp + 32'd4;
            end
        end
        nobr();
`ifdef BRANCH_PERF_EN
        @(negedge clk);
        chk1("perf_br_sat", {28'd0, perf_branches}, 32'hF);
        chk1("perf_mp_sat", {28'd0, perf_mispredicts}, 32'hF);
        @(posedge clk);
        #1;
        pexp = pexp + 32'd4;
`endif

        // Reset in the middle of a drain
        imem_ready = 1'b0;
        br(1'b1, 1'b1, 32'h0, 32'h7000);
        cyc("pre_rst_mp", pexp, 1'b1, 1'b0, 1'b1);
        nobr();
        cyc("pre_rst_drain", pexp, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        cyc("rst_in_drain", pexp, 1'b0, 1'b0, 1'b0);
        rst        = 1'b0;
        imem_ready = 1'b1;
        cyc("post_rst0", 32'h0, 1'b1, 1'b1, 1'b0);
        cyc("post_rst1", 32'h4, 1'b1, 1'b1, 1'b0);
`ifdef BRANCH_PERF_EN
        @(negedge clk);
        chk1("perf_br_clr", {28'd0, perf_branches}, 32'h0);
        chk1("perf_mp_clr", {28'd0, perf_mispredicts}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
